checkpoint_recovery_ctrl: RTL

//  Branch-resolution end of the checkpoint protocol. Consumes resolved-branch results.

---
 rtl/riscv_cp_pkg.sv | 21 ++
 rtl/checkpoint_recovery_ctrl_oldest_select.sv | 28 ++
 rtl/checkpoint_recovery_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/riscv_cp_pkg.sv
// riscv_cp_pkg: shared checkpoint-recovery types, sizes and line field offsets
package riscv_cp_pkg;
  localparam int NUM_CP = 8;
  localparam int CPW = $clog2(NUM_CP);
  localparam int NUM_RES = 3;
  localparam int AL_SIZE = 32;
  localparam int ALW = $clog2(AL_SIZE);
  localparam int LINE_SIZE = 3*ALW+660;
  localparam int FL_SIZE_LSB = 384;
  localparam int FL_FRONT_LSB = 391;
  localparam int FL_BACK_LSB = 397;
  localparam int AL_FRONT_LSB = 403;
  localparam int RMT_LSB = 3*ALW+404;
  localparam int BBL_LSB = RMT_LSB+192;
  typedef logic [CPW-1:0] cp_id_t;
  typedef logic [ALW-1:0] al_idx_t;
  typedef enum logic [1:0] {IDLE, RECALL, RESTORE, DRAIN} recov_state_e;
  function automatic cp_id_t cp_age(input cp_id_t id, input cp_id_t oldest);
    return id - oldest;
  endfunction
endpackage

// File: rtl/checkpoint_recovery_ctrl_oldest_select.sv
// cp_oldest_select: picks the oldest mispredicting lane, lower lane wins ties
module cp_oldest_select
  import riscv_cp_pkg::*;
(
  input  logic [NUM_RES-1:0]       mis_i,
  input  cp_id_t [NUM_RES-1:0]     id_i,
  input  logic [NUM_RES-1:0][63:0] target_i,
  input  cp_id_t                   oldest_i,
  output logic                     hit_o,
  output cp_id_t                   id_o,
  output logic [63:0]              target_o,
  output cp_id_t                   age_o
);
  // strict compare keeps the earlier (lower) lane on equal age
  always_comb begin
    hit_o = 1'b0;
    id_o = '0;
    target_o = '0;
    age_o = '0;
    for (int l = 0; l < NUM_RES; l++)
      if (mis_i[l] && (!hit_o || cp_age(id_i[l], oldest_i) < age_o)) begin
        hit_o = 1'b1;
        id_o = id_i[l];
        target_o = target_i[l];
        age_o = cp_age(id_i[l], oldest_i);
      end
  end
endmodule

// File: rtl/checkpoint_recovery_ctrl.sv
// checkpoint_recovery_ctrl: validates correct branches, recalls and restores on the oldest mispredict
module checkpoint_recovery_ctrl
  import riscv_cp_pkg::*;
#(
  parameter int DRAIN_CYC = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RES-1:0]       res_valid,
  input  logic [NUM_RES-1:0]       res_mispredict,
  input  cp_id_t [NUM_RES-1:0]     res_cp_id,
  input  logic [NUM_RES-1:0][63:0] res_target,
  input  cp_id_t                   oldest_cp_id,
  output logic [NUM_RES-1:0]       validate,
  output cp_id_t [NUM_RES-1:0]     validated_id,
  output logic                     recall_checkpoint,
  output cp_id_t                   recall_id,
  input  logic [LINE_SIZE-1:0]     recalled_data,
  output logic                     restore_valid,
  output logic [31:0][5:0]         rmt_restore,
  output logic [63:0][5:0]         fl_list_restore,
  output logic [6:0]               fl_size_restore,
  output logic [5:0]               fl_front_restore,
  output logic [5:0]               fl_back_restore,
  output al_idx_t                  al_front_restore,
  output logic [63:0]              bbl_restore,
  output logic                     redirect_valid,
  output logic [63:0]              redirect_pc,
  output logic                     recovery_busy
);
  recov_state_e state_q, state_d;
  cp_id_t id_q, id_d, sel_id, sel_age, lat_age, lim_age;
  logic [63:0] tgt_q, tgt_d, sel_tgt;
  logic [2:0] cnt_q, cnt_d;
  logic [LINE_SIZE-1:0] line_q, line_d;
  logic [NUM_RES-1:0] validate_q, validate_d;
  cp_id_t [NUM_RES-1:0] vid_q, vid_d;
  logic sel_hit, busy, take, lim_act;
  cp_oldest_select u_sel (
    .mis_i(res_valid & res_mispredict),
    .id_i(res_cp_id),
    .target_i(res_target),
    .oldest_i(oldest_cp_id),
    .hit_o(sel_hit),
    .id_o(sel_id),
    .target_o(sel_tgt),
    .age_o(sel_age)
  );
  assign busy = state_q != IDLE;
  assign lat_age = cp_age(id_q, oldest_cp_id);
  assign take = sel_hit && (!busy || sel_age < lat_age);
  assign lim_act = take || busy;
  assign lim_age = take ? sel_age : lat_age;
  // next state, latch, drain counter, line capture and validate filtering
  always_comb begin
    state_d = take ? RECALL : state_q == RECALL ? RESTORE : state_q == RESTORE ? DRAIN :
              (state_q == DRAIN && cnt_q == 3'd0) ? IDLE : state_q;
    id_d = take ? sel_id : id_q;
    tgt_d = take ? sel_tgt : tgt_q;
    cnt_d = state_q == RESTORE ? 3'(DRAIN_CYC-1) : state_q == DRAIN ? cnt_q - 3'd1 : cnt_q;
    line_d = state_q == RECALL ? recalled_data : line_q;
    vid_d = res_cp_id;
    for (int i = 0; i < NUM_RES; i++)
      validate_d[i] = res_valid[i] && !res_mispredict[i] &&
                      (!lim_act || cp_age(res_cp_id[i], oldest_cp_id) < lim_age);
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q <= '0;
      tgt_q <= '0;
      cnt_q <= '0;
      line_q <= '0;
      validate_q <= '0;
      vid_q <= '0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
      line_q <= line_d;
      validate_q <= validate_d;
      vid_q <= vid_d;
    end
  end
  // unpack the captured checkpoint line into restore fields
  always_comb begin
    for (int k = 0; k < 64; k++) fl_list_restore[k] = line_q[6*k+:6];
    for (int r = 0; r < 32; r++) rmt_restore[r] = line_q[RMT_LSB+6*r+:6];
  end
  assign fl_size_restore = line_q[FL_SIZE_LSB+:7];
  assign fl_front_restore = line_q[FL_FRONT_LSB+:6];
  assign fl_back_restore = line_q[FL_BACK_LSB+:6];
  assign al_front_restore = line_q[AL_FRONT_LSB+:ALW];
  assign bbl_restore = line_q[BBL_LSB+:64];
  assign validate = validate_q;
  assign validated_id = vid_q;
  assign recall_checkpoint = state_q == RECALL;
  assign recall_id = id_q;
  assign restore_valid = state_q == RESTORE;
  assign redirect_valid = state_q == RESTORE;
  assign redirect_pc = tgt_q;
  assign recovery_busy = busy;
endmodule
